seg_scan_driver: RTL

Time-multiplexed scan driver for a multi-digit common-select seven-segment display. Holds a DIGITS-wide packed hex value, cycles through the digits at a programmable refresh rate, and presents one 4-bit nibble per slot to the downstream hex-to-segment decoder together with a one-hot digit select and decimal point. New values are double-buffered and applied only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_scan_tick.sv | 40 ++++
 rtl/seg_scan_driver.sv | 109 ++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg_pkg;

  localparam int NIBBLE_W        = 4;
  localparam int MAX_DIGITS      = 8;
  localparam int DEF_REFRESH_DIV = 50000;
  localparam int DEF_GUARD       = 2;

  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Slot prescaler: counts REFRESH_DIV cycles per digit slot and flags the
// post-guard portion of each slot in which a digit select may be driven.
module seg_scan_tick
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int GUARD       = DEF_GUARD
) (
  input  logic clk,
  input  logic rst,
  output logic o_slot_tick,
  output logic o_sel_en
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_slot_tick = (r_cnt == CNT_MAX);

  generate
    if (GUARD == 0) begin : g_no_guard
      assign o_sel_en = 1'b1;
    end else begin : g_guard
      assign o_sel_en = (r_cnt >= CNT_W'(GUARD));
    end
  endgenerate

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-aligned double buffering.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int GUARD       = DEF_GUARD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [NIBBLE_W*DIGITS-1:0] value_in,
  input  logic [DIGITS-1:0]        dp_in,
  output logic                     ready,
  output logic [NIBBLE_W-1:0]      hex_out,
  output logic [DIGITS-1:0]        digit_sel,
  output logic                     dp_out,
  output logic                     frame_tick
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic                       w_slot_tick;
  logic                       w_sel_en;
  logic                       w_frame;
  logic                       w_blank;
  logic [MAX_DIGITS-1:0]      w_onehot;

  logic [IDX_W-1:0]           r_idx;
  logic [NIBBLE_W*DIGITS-1:0] r_disp;
  logic [DIGITS-1:0]          r_dpd;
  logic [NIBBLE_W*DIGITS-1:0] r_pend;
  logic [DIGITS-1:0]          r_dpp;
  logic                       r_pf;

  seg_scan_tick #(
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD       (GUARD)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .o_slot_tick (w_slot_tick),
    .o_sel_en    (w_sel_en)
  );

  assign w_frame = w_slot_tick && (r_idx == IDX_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_slot_tick) begin
      r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // A load on the boundary bypasses the pending buffer and supersedes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp <= '0;
      r_dpd  <= '0;
      r_pend <= '0;
      r_dpp  <= '0;
      r_pf   <= 1'b0;
    end else if (load && w_frame) begin
      r_disp <= value_in;
      r_dpd  <= dp_in;
      r_pf   <= 1'b0;
    end else if (load) begin
      r_pend <= value_in;
      r_dpp  <= dp_in;
      r_pf   <= 1'b1;
    end else if (w_frame && r_pf) begin
      r_disp <= r_pend;
      r_dpd  <= r_dpp;
      r_pf   <= 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] w_blank_vec;
  logic              w_above_zero;

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    w_blank_vec  = '0;
    w_above_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      w_above_zero = w_above_zero
                     && (r_disp[(DIGITS-1-k)*NIBBLE_W +: NIBBLE_W] == '0)
                     && !r_dpd[DIGITS-1-k];
      w_blank_vec[DIGITS-1-k] = w_above_zero;
    end
  end

  assign w_blank = w_blank_vec[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  assign w_onehot   = onehot(3'(r_idx));
  assign ready      = !r_pf;
  assign hex_out    = r_disp[r_idx*NIBBLE_W +: NIBBLE_W];
  assign dp_out     = r_dpd[r_idx];
  assign digit_sel  = (w_sel_en && !w_blank) ? w_onehot[DIGITS-1:0] : '0;
  assign frame_tick = w_frame;

endmodule
